conf_int_sub__pipe__arch_agnos: RTL

Configurable-precision, two-stage pipelined integer subtractor: d = a − b over DATA_PATH_BITWIDTH bits, with only the top OP_BITWIDTH bits of each operand significant. It is the inverse-direction counterpart of the combinational configurable adder in the approximate integer operator library. It provides a borrow flag and valid/ready handshakes on both sides, so it can sit in elastic datapaths. The borrow chain is split across two register stages to shorten the critical path.

---
 rtl/conf_int_sub__pipe__arch_agnos.sv | 78 +++++++
 1 files changed

// File: rtl/conf_int_sub__pipe__arch_agnos.sv
// Two-stage pipelined configurable-precision subtractor d = a - b.
// The borrow chain is split into a low slice (stage 1) and a high slice (stage 2).
module conf_int_sub__pipe__arch_agnos #(
    parameter int unsigned OP_BITWIDTH        = 16,
    parameter int unsigned DATA_PATH_BITWIDTH = 16,
    parameter int unsigned LO_WIDTH           = DATA_PATH_BITWIDTH / 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          borrow
);
    localparam int unsigned HI_WIDTH = DATA_PATH_BITWIDTH - LO_WIDTH;
    localparam logic [DATA_PATH_BITWIDTH-1:0] MASK =
        {DATA_PATH_BITWIDTH{1'b1}} << (DATA_PATH_BITWIDTH - OP_BITWIDTH);

    logic [DATA_PATH_BITWIDTH-1:0] a_m, b_m;
    logic [LO_WIDTH:0]             lo_diff;
    logic [HI_WIDTH:0]             hi_diff;

    logic                s1_valid;
    logic [LO_WIDTH-1:0] lo_q;
    logic                bl_q;
    logic [HI_WIDTH-1:0] a_hi_q, b_hi_q;

    logic s2_load, s1_adv, in_xfer;

    assign a_m = a & MASK;
    assign b_m = b & MASK;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = rst && (!s1_valid || s2_load);
    assign in_xfer  = in_valid && in_ready;

    // Extra MSB on each slice difference carries the borrow-out.
    assign lo_diff = {1'b0, a_m[LO_WIDTH-1:0]} - {1'b0, b_m[LO_WIDTH-1:0]};
    assign hi_diff = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{HI_WIDTH{1'b0}}, bl_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lo_q   <= lo_diff[LO_WIDTH-1:0];
            bl_q   <= lo_diff[LO_WIDTH];
            a_hi_q <= a_m[DATA_PATH_BITWIDTH-1:LO_WIDTH];
            b_hi_q <= b_m[DATA_PATH_BITWIDTH-1:LO_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            borrow    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            d         <= {hi_diff[HI_WIDTH-1:0], lo_q};
            borrow    <= hi_diff[HI_WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
